ysyx_22050612_wb_ctrl: RTL and testbench
========================================

Name: ysyx_22050612_wb_ctrl

Overview:
- Write-back controller: the writing end of the integer register file's write port (wen/waddr/wdata).
- Merges results from two producers, ALU and LSU, into a single registered write per cycle.
- ALU results are single-cycle. LSU results are buffered in a small FIFO.
- Keeps a per-register busy scoreboard. Issue logic uses it to stall reads of registers with pending writes.

Parameters:
- ADDR_WIDTH, 5, register index width; register file has 2**ADDR_WIDTH entries.
- DATA_WIDTH, 64, register data width.
- LSU_FIFO_DEPTH, 4, LSU result buffer entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- lsu_valid  in  1  load result present.
- lsu_ready  out  1  LSU FIFO can accept.
- lsu_rd  in  ADDR_WIDTH  load destination register.
- lsu_data  in  DATA_WIDTH  load result.
- alloc_valid  in  1  issue stage reserves a destination.
- alloc_rd  in  ADDR_WIDTH  reserved register.
- wen  out  1  register file write enable.
- waddr  out  ADDR_WIDTH  register file write address.
- wdata  out  DATA_WIDTH  register file write data.
- busy  out  2**ADDR_WIDTH  per-register pending-write bitmap.
- lsu_count  out  $clog2(LSU_FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset, while rst=1 at a posedge:
  - wen=0, waddr=0, wdata=0, busy=0.
  - FIFO emptied; lsu_count=0.
  - alu_ready=0 and lsu_ready=0 combinationally while rst=1.
  - Reset mid-operation discards all buffered and in-flight results; no write is issued for them.
- Handshakes:
  - Transfer occurs when valid && ready at a posedge.
  - alu_ready = !rst; the ALU is never stalled.
  - lsu_ready = !rst && (lsu_count != LSU_FIFO_DEPTH).
  - When full, no enqueue occurs even if a pop happens in the same cycle.
- Arbitration, at most one commit per cycle:
  - An ALU transfer in cycle N commits: at the N+1 edge, wen=1, waddr=alu_rd, wdata=alu_data.
  - The FIFO head pops in cycle N only if the FIFO is non-empty and no ALU transfer occurs in cycle N; wen/waddr/wdata update at the N+1 edge.
  - There is no LSU bypass. Minimum load latency is 2 cycles: enqueue at N, pop at N+1, wen visible after the N+2 edge.
- Cycles with no commit: wen=0; waddr and wdata hold their last values.
- FIFO:
  - Circular, with read/write pointers one bit wider than the index.
  - lsu_count = wptr - rptr.
  - Enqueue and pop in the same cycle leave the count unchanged.
  - Order is preserved.
- x0 writes: a commit with rd=0 consumes the entry and updates waddr/wdata, but wen=0.
- Scoreboard:
  - busy[i] sets at the edge where alloc_valid && alloc_rd=i, for i≠0.
  - busy[i] clears at the edge where wen=1 && waddr=i. This is the same edge at which the register file absorbs the write.
  - If set and clear hit the same i in the same cycle, set wins and busy[i] stays 1.
  - busy[0] is constant 0.
- Ordering: there is no cross-source ordering guarantee. Write-after-write to the same rd is prevented by issue logic through busy.

Optional Feature:
- Macro: YSYX_22050612_WB_TRACE_EN.
- Defined:
  - Every posedge with wen=1 prints waddr, wdata and the source (ALU/LSU) via $display. The source is tracked by a registered flag.
  - Simulation asserts $error on an LSU enqueue while full, and on a commit to rd≠0 whose busy bit is 0.
- Undefined:
  - No display or assertion logic, and no source flag.
  - Ports and functional behaviour are identical.

Test Plan:
- rst for 2 cycles, then idle -> wen=0, busy=0, lsu_ready=1, alu_ready=1, lsu_count=0.
- alloc_rd=5 at cycle 0; ALU valid rd=5 data=0x1234 at cycle 1 -> cycle 2: wen=1, waddr=5, wdata=0x1234; busy[5] drops to 0 in cycle 3.
- LSU rd=7 data=0xAA and ALU rd=3 data=0xBB in the same cycle N, ALU idle afterwards -> N+1: write reg 3; N+2: write reg 7.
- 4 LSU transfers while ALU is continuously valid -> lsu_count=4, lsu_ready=0, 5th lsu_valid held. ALU stops -> FIFO drains in order, one write per cycle.
- ALU rd=0 data=0xFF -> next cycle wen=0, waddr=0, wdata=0xFF; busy unchanged.
- Same cycle: commit clears reg 9 and alloc_rd=9 -> busy[9]=1 afterwards. Separately, assert rst with 3 FIFO entries -> all discarded, no further wen.

Source files
------------

// File: rtl/ysyx_22050612_wb_ctrl.sv
// Write-back controller: merges single-cycle ALU results and FIFO-buffered LSU results into one
// registered register-file write per cycle, with a busy scoreboard. Optional trace: YSYX_22050612_WB_TRACE_EN.
module ysyx_22050612_wb_ctrl #(
   parameter int ADDR_WIDTH     = 5,
   parameter int DATA_WIDTH     = 64,
   parameter int LSU_FIFO_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             alu_valid,
   output logic                             alu_ready,
   input  logic [ADDR_WIDTH-1:0]            alu_rd,
   input  logic [DATA_WIDTH-1:0]            alu_data,
   input  logic                             lsu_valid,
   output logic                             lsu_ready,
   input  logic [ADDR_WIDTH-1:0]            lsu_rd,
   input  logic [DATA_WIDTH-1:0]            lsu_data,
   input  logic                             alloc_valid,
   input  logic [ADDR_WIDTH-1:0]            alloc_rd,
   output logic                             wen,
   output logic [ADDR_WIDTH-1:0]            waddr,
   output logic [DATA_WIDTH-1:0]            wdata,
   output logic [2**ADDR_WIDTH-1:0]         busy,
   output logic [$clog2(LSU_FIFO_DEPTH):0]  lsu_count
);

   localparam int IDX_W    = $clog2(LSU_FIFO_DEPTH);
   localparam int NUM_REGS = 2**ADDR_WIDTH;
   localparam logic [IDX_W:0] FULL_CNT = LSU_FIFO_DEPTH[IDX_W:0];
   localparam logic [IDX_W:0] PTR_ONE  = 1;

   logic [ADDR_WIDTH-1:0] fifo_rd   [LSU_FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data [LSU_FIFO_DEPTH];
   logic [IDX_W:0]        wptr;
   logic [IDX_W:0]        rptr;
   logic                  alu_fire;
   logic                  lsu_fire;
   logic                  fifo_empty;
   logic                  pop;
   logic [ADDR_WIDTH-1:0] head_rd;
   logic [DATA_WIDTH-1:0] head_data;
   logic [NUM_REGS-1:0]   busy_nxt;

   assign alu_ready  = !rst;
   assign lsu_count  = wptr - rptr;
   assign lsu_ready  = !rst && (lsu_count != FULL_CNT);
   assign fifo_empty = (wptr == rptr);
   assign alu_fire   = alu_valid && alu_ready;
   assign lsu_fire   = lsu_valid && lsu_ready;
   // ALU owns the write port whenever it fires; the FIFO head waits.
   assign pop        = !fifo_empty && !alu_fire;
   assign head_rd    = fifo_rd[rptr[IDX_W-1:0]];
   assign head_data  = fifo_data[rptr[IDX_W-1:0]];

   always_ff @(posedge clk) begin
      if (lsu_fire) begin
         fifo_rd[wptr[IDX_W-1:0]]   <= lsu_rd;
         fifo_data[wptr[IDX_W-1:0]] <= lsu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (lsu_fire) wptr <= wptr + PTR_ONE;
         if (pop)      rptr <= rptr + PTR_ONE;
      end
   end

   // Writes to x0 still consume the entry and move waddr/wdata, but never assert wen.
   always_ff @(posedge clk) begin
      if (rst) begin
         wen   <= 1'b0;
         waddr <= '0;
         wdata <= '0;
      end else if (alu_fire) begin
         wen   <= (alu_rd != '0);
         waddr <= alu_rd;
         wdata <= alu_data;
      end else if (pop) begin
         wen   <= (head_rd != '0);
         waddr <= head_rd;
         wdata <= head_data;
      end else begin
         wen   <= 1'b0;
      end
   end

   // Clear on the edge the register file absorbs the write; a same-cycle allocation wins.
   always_comb begin
      busy_nxt = busy;
      if (wen) busy_nxt[waddr] = 1'b0;
      if (alloc_valid) busy_nxt[alloc_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

`ifdef YSYX_22050612_WB_TRACE_EN
   logic src_lsu;

   always_ff @(posedge clk) begin
      if (rst)           src_lsu <= 1'b0;
      else if (alu_fire) src_lsu <= 1'b0;
      else if (pop)      src_lsu <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (wen)
            $display("wb: x%0d <= %h (%s)", waddr, wdata, src_lsu ? "LSU" : "ALU");
         if (lsu_fire && (lsu_count == FULL_CNT))
            $error("wb: LSU enqueue while FIFO full");
         if (wen && (waddr != '0) && !busy[waddr])
            $error("wb: commit to x%0d without pending busy bit", waddr);
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_22050612_wb_ctrl.sv
// Bench for ysyx_22050612_wb_ctrl: directed scenarios then random traffic against a queue-based model.
module tb_ysyx_22050612_wb_ctrl;

   localparam int AW    = 5;
   localparam int DW    = 64;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid, lsu_valid, alloc_valid;
   logic          alu_ready, lsu_ready;
   logic [AW-1:0] alu_rd, lsu_rd, alloc_rd;
   logic [DW-1:0] alu_data, lsu_data;
   logic          wen;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [31:0]   busy;
   logic [2:0]    lsu_count;

   always #5 clk = ~clk;

   ysyx_22050612_wb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LSU_FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
      .wen(wen), .waddr(waddr), .wdata(wdata), .busy(busy), .lsu_count(lsu_count)
   );

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } ent_t;

   ent_t          mq[$];
   logic          m_wen;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   logic [31:0]   m_busy;
   int            checks   = 0;
   int            failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      alu_valid = 0; alu_rd = '0; alu_data = '0;
      lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
      alloc_valid = 0; alloc_rd = '0;
   endtask

   // One clock: check handshake outputs, cross the edge, advance the model, check the write port.
   task automatic step();
      int            cnt;
      ent_t          e;
      logic          have;
      logic [AW-1:0] c_rd;
      logic [DW-1:0] c_data;
      logic [31:0]   nb;
      #1;
      cnt = mq.size();
      chk("alu_ready", alu_ready, !rst);
      chk("lsu_ready", lsu_ready, !rst && (cnt < DEPTH));
      chk("lsu_count", lsu_count, cnt);
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_wen = 0; m_waddr = '0; m_wdata = '0; m_busy = '0;
      end else begin
         nb = m_busy;
         if (m_wen) nb[m_waddr] = 1'b0;
         if (alloc_valid && alloc_rd != 0) nb[alloc_rd] = 1'b1;
         m_busy = nb;
         have = 0; c_rd = '0; c_data = '0;
         if (alu_valid) begin
            have = 1; c_rd = alu_rd; c_data = alu_data;
         end else if (cnt > 0) begin
            e = mq.pop_front();
            have = 1; c_rd = e.rd; c_data = e.data;
         end
         if (have) begin
            m_wen = (c_rd != 0); m_waddr = c_rd; m_wdata = c_data;
         end else begin
            m_wen = 0;
         end
         if (lsu_valid && cnt < DEPTH) mq.push_back('{lsu_rd, lsu_data});
      end
      #1;
      chk("wen", wen, m_wen);
      chk("waddr", waddr, m_waddr);
      chk("wdata", wdata, m_wdata);
      chk("busy", busy, m_busy);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      mq.delete();
      m_wen = 0; m_waddr = '0; m_wdata = '0; m_busy = '0;
      rst = 1;
      idle_inputs();
      @(posedge clk);
      #1;

      // Reset held two cycles, then idle
      step(); step();
      rst = 0;
      step();
      chk("idle_wen", wen, 0);
      chk("idle_busy", busy, 0);

      // Allocate x5, ALU writes it, busy drops the cycle after the write
      alloc_valid = 1; alloc_rd = 5;
      step();
      alloc_valid = 0;
      alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
      step();
      chk("alu_wen", wen, 1);
      chk("alu_waddr", waddr, 5);
      chk("alu_wdata", wdata, 64'h1234);
      chk("alu_busy5_held", busy[5], 1);
      idle_inputs();
      step();
      chk("alu_busy5_clr", busy[5], 0);

      // Same-cycle ALU and LSU: ALU first, load one cycle later
      alu_valid = 1; alu_rd = 3; alu_data = 64'hBB;
      lsu_valid = 1; lsu_rd = 7; lsu_data = 64'hAA;
      step();
      chk("arb_first", waddr, 3);
      idle_inputs();
      step();
      chk("arb_second_addr", waddr, 7);
      chk("arb_second_wen", wen, 1);
      step();

      // Fill FIFO behind a continuously valid ALU, then drain in order
      for (int i = 0; i < 5; i++) begin
         alu_valid = 1; alu_rd = AW'(1 + i); alu_data = 64'(100 + i);
         lsu_valid = 1; lsu_rd = AW'(10 + (i < 4 ? i : 10)); lsu_data = 64'(200 + i);
         step();
      end
      chk("full_count", lsu_count, 4);
      chk("full_ready", lsu_ready, 0);
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         step();
         chk("drain_addr", waddr, 10 + i);
         chk("drain_data", wdata, 200 + i);
      end
      step();
      chk("drain_done_wen", wen, 0);

      // Write to x0
      alu_valid = 1; alu_rd = 0; alu_data = 64'hFF;
      step();
      chk("x0_wen", wen, 0);
      chk("x0_waddr", waddr, 0);
      chk("x0_wdata", wdata, 64'hFF);
      idle_inputs();

      // Set beats clear on the same register
      alloc_valid = 1; alloc_rd = 9;
      step();
      alloc_valid = 0;
      alu_valid = 1; alu_rd = 9; alu_data = 64'h99;
      step();
      alu_valid = 0;
      alloc_valid = 1; alloc_rd = 9;
      step();
      chk("setclr_busy9", busy[9], 1);
      idle_inputs();
      step();
      chk("setclr_busy9_hold", busy[9], 1);

      // Reset with three buffered loads discards them
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1; alu_rd = 2; alu_data = 64'(i);
         lsu_valid = 1; lsu_rd = AW'(20 + i); lsu_data = 64'(300 + i);
         step();
      end
      chk("pre_rst_count", lsu_count, 3);
      idle_inputs();
      rst = 1;
      step();
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_wen", wen, 0);
         chk("post_rst_count", lsu_count, 0);
      end

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rst         = ($urandom_range(0, 59) == 0);
         alu_valid   = ($urandom_range(0, 2) == 0);
         alu_rd      = AW'($urandom_range(0, 31));
         alu_data    = {$urandom, $urandom};
         lsu_valid   = ($urandom_range(0, 1) == 0);
         lsu_rd      = AW'($urandom_range(0, 31));
         lsu_data    = {$urandom, $urandom};
         alloc_valid = ($urandom_range(0, 1) == 0);
         alloc_rd    = AW'($urandom_range(0, 31));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
